// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: register map, CTRL/STATUS bit
// positions, FSM state encoding and the CTRL register layout.
package timer_pkg;

  localparam logic [1:0] A_RELOAD = 2'd0;
  localparam logic [1:0] A_CTRL   = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_ACK    = 2'd3;

  localparam int C_EN     = 0;
  localparam int C_AUTO   = 1;
  localparam int C_DIR    = 2;
  localparam int C_IRQ_EN = 3;
  localparam int C_CLR    = 4;

  localparam int ACK_BIT  = 0;

  localparam int S_PEND   = 0;
  localparam int S_STATE  = 1;
  localparam int S_EXP    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  typedef struct packed {
    logic irq_en;
    logic dir;
    logic auto_rl;
    logic en;
  } ctrl_t;

  // Readback image of CTRL; the self-clearing clr bit always reads as zero.
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] word;
    word           = 32'h0000_0000;
    word[C_EN]     = c.en;
    word[C_AUTO]   = c.auto_rl;
    word[C_DIR]    = c.dir;
    word[C_IRQ_EN] = c.irq_en;
    return word;
  endfunction

endpackage

// File: rtl/timer_if.sv
// CPU-side register bus of the timer controller: write strobe, address,
// write data and combinational read data.
interface timer_if;

  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output wr_en,
    output addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  addr,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/timer_regs.sv
// RELOAD and CTRL storage plus the read-data mux. Mode bits (dir/auto) only
// change while the timer is idle so a running count never flips behaviour.
module timer_regs
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wr_data,
  input  state_e      i_state,
  input  logic        i_en_clr,
  input  logic [31:0] i_status,
  output logic [31:0] o_reload,
  output ctrl_t       o_ctrl,
  output logic [31:0] o_rd_data
);

  logic        w_wr_reload;
  logic        w_wr_ctrl;
  logic        w_mode_wr;
  logic        w_clr;
  logic [31:0] r_reload;
  ctrl_t       r_ctrl;

  assign w_wr_reload = i_wr_en & (i_addr == A_RELOAD);
  assign w_wr_ctrl   = i_wr_en & (i_addr == A_CTRL);
  assign w_mode_wr   = w_wr_ctrl & (i_state == ST_IDLE);
  assign w_clr       = w_wr_ctrl & i_wr_data[C_CLR];

  // RELOAD register; a new value only takes effect at the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reload <= 32'h0000_0000;
    end else if (w_wr_reload) begin
      r_reload <= i_wr_data;
    end
  end

  // CTRL register; en drops on clr or one-shot expiry, both beating a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= ctrl_t'(4'b0000);
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl.irq_en <= i_wr_data[C_IRQ_EN];
      end
      if (w_mode_wr) begin
        r_ctrl.dir     <= i_wr_data[C_DIR];
        r_ctrl.auto_rl <= i_wr_data[C_AUTO];
      end
      if (i_en_clr || w_clr) begin
        r_ctrl.en <= 1'b0;
      end else if (w_wr_ctrl) begin
        r_ctrl.en <= i_wr_data[C_EN];
      end
    end
  end

  // Combinational read mux
  always_comb begin
    o_rd_data = 32'h0000_0000;
    case (i_addr)
      A_RELOAD: o_rd_data = r_reload;
      A_CTRL:   o_rd_data = ctrl_to_word(r_ctrl);
      A_STATUS: o_rd_data = i_status;
      A_ACK:    o_rd_data = 32'h0000_0000;
      default:  o_rd_data = 32'h0000_0000;
    endcase
  end

  assign o_reload = r_reload;
  assign o_ctrl   = r_ctrl;

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: sequences the external up/down counter through idle,
// run and pause, qualifies its terminal-count flag and raises a level IRQ.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int EXP_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  timer_if.slave      bus,
  input  logic [31:0] i_cnt,
  input  logic        i_rc,
  output logic        o_load,
  output logic [31:0] o_pdata,
  output logic        o_s,
  output logic        o_irq
);

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  state_e             r_state;
  state_e             w_next_state;
  logic               r_load_d;
  logic               r_irq_pend;
  logic [EXP_W-1:0]   r_exp_cnt;
  logic               w_rc_valid;
  logic               w_wr_ctrl;
  logic               w_clr;
  logic               w_en_wr;
  logic               w_ack;
  logic               w_en_clr;
  logic [31:0]        w_reload;
  logic [31:0]        w_status;
  ctrl_t              w_ctrl;

  assign w_wr_ctrl = bus.wr_en & (bus.addr == A_CTRL);
  assign w_clr     = w_wr_ctrl & bus.wr_data[C_CLR];
  assign w_en_wr   = bus.wr_data[C_EN];
  assign w_ack     = bus.wr_en & (bus.addr == A_ACK) & bus.wr_data[ACK_BIT];

  // Rc is not refreshed by the counter on a load cycle, so it is stale for
  // the cycle after any Load and is only meaningful while running.
  assign w_rc_valid = i_rc & ~r_load_d & (r_state == ST_RUN);
  assign w_en_clr   = w_rc_valid & ~w_ctrl.auto_rl;

  timer_regs u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (bus.wr_en),
    .i_addr    (bus.addr),
    .i_wr_data (bus.wr_data),
    .i_state   (r_state),
    .i_en_clr  (w_en_clr),
    .i_status  (w_status),
    .o_reload  (w_reload),
    .o_ctrl    (w_ctrl),
    .o_rd_data (bus.rd_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state; clr dominates, a pause write beats a coincident expiry
  always_comb begin
    w_next_state = r_state;
    if (w_clr) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_wr_ctrl && w_en_wr) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_wr_ctrl && !w_en_wr) begin
            w_next_state = ST_PAUSE;
          end else if (w_rc_valid && !w_ctrl.auto_rl) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (w_wr_ctrl && w_en_wr) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_state = ST_PAUSE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: pause freezes the counter by reloading its own value
  always_comb begin
    o_load  = 1'b1;
    o_pdata = w_reload;
    case (r_state)
      ST_IDLE: begin
        o_load  = 1'b1;
        o_pdata = w_reload;
      end
      ST_RUN: begin
        o_load  = w_rc_valid & w_ctrl.auto_rl;
        o_pdata = w_reload;
      end
      ST_PAUSE: begin
        o_load  = 1'b1;
        o_pdata = i_cnt;
      end
      default: begin
        o_load  = 1'b1;
        o_pdata = w_reload;
      end
    endcase
  end

  // Registered copy of Load used to mask the stale Rc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_d <= 1'b1;
    end else begin
      r_load_d <= o_load;
    end
  end

  // Pending interrupt; a new expiry wins over a same-cycle acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_pend <= 1'b0;
    end else if (w_rc_valid) begin
      r_irq_pend <= 1'b1;
    end else if (w_ack) begin
      r_irq_pend <= 1'b0;
    end
  end

  // Saturating expiry counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_cnt <= {EXP_W{1'b0}};
    end else if (w_clr) begin
      r_exp_cnt <= {EXP_W{1'b0}};
    end else if (w_rc_valid && (r_exp_cnt != EXP_MAX)) begin
      r_exp_cnt <= r_exp_cnt + EXP_W'(1);
    end
  end

  // STATUS image
  always_comb begin
    w_status                 = 32'h0000_0000;
    w_status[S_EXP +: EXP_W] = r_exp_cnt;
    w_status[S_STATE +: 2]   = r_state;
    w_status[S_PEND]         = r_irq_pend;
  end

  assign o_s   = w_ctrl.dir;
  assign o_irq = r_irq_pend & w_ctrl.irq_en;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: models the external counter and checks
// load timing and expiry counts against period arithmetic.
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_rc = 1'b0;
  logic        force_rc = 1'b0;
  logic        tb_rc;
  logic        cap_load = 1'b1;
  logic        cap_s = 1'b0;
  logic [31:0] cap_pdata = 32'h0;
  logic        o_load;
  logic        o_s;
  logic        o_irq;
  logic [31:0] o_pdata;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  timer_if bus ();

  assign tb_rc = m_rc | force_rc;

  timer_ctrl #(.EXP_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .i_cnt   (m_cnt),
    .i_rc    (tb_rc),
    .o_load  (o_load),
    .o_pdata (o_pdata),
    .o_s     (o_s),
    .o_irq   (o_irq)
  );

  // Counter model: load or count; Rc flags the terminal value, held on loads
  always @(negedge clk) begin
    cap_load  = o_load;
    cap_pdata = o_pdata;
    cap_s     = o_s;
  end

  always @(posedge clk) begin
    if (cap_load) begin
      m_cnt <= cap_pdata;
    end else begin
      m_cnt <= cap_s ? m_cnt + 32'd1 : m_cnt - 32'd1;
      m_rc  <= cap_s ? (m_cnt == 32'hFFFF_FFFF) : (m_cnt == 32'h0);
    end
  end

  function automatic longint period(input logic [31:0] rl, input bit up);
    if (up) return 64'sh1_0000_0000 - longint'({32'h0, rl}) + 64'sd1;
    else    return longint'({32'h0, rl}) + 64'sd2;
  endfunction

  function automatic logic [31:0] status_exp(input int e, input int st, input bit pend);
    return (32'(e) << 16) | (32'(st) << 1) | 32'(pend);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.addr    = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rd_data;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Running cycles n0..n1-1 after enable: Load pulses exactly at n mod P == P-1
  task automatic run_load(input int n0, input int n1, input longint p);
    for (int n = n0; n < n1; n++) begin
      chkb("load_timing", o_load, (longint'(n) % p) == (p - 64'sd1));
      tick();
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] r;
    longint      p;
    int          n;
    bit          up;
    bit          ie;

    bus.wr_en   = 1'b0;
    bus.addr    = 2'd0;
    bus.wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_load", o_load, 1'b1);
    chk("rst_pdata", o_pdata, 32'h0);
    chkb("rst_s", o_s, 1'b0);
    chkb("rst_irq", o_irq, 1'b0);
    rst_n = 1'b1;
    tick();
    tick();
    rd(2'd2, d); chk("status_rst", d, 32'h0);
    rd(2'd0, d); chk("reload_rst", d, 32'h0);
    rd(2'd1, d); chk("ctrl_rst", d, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, d); chk("status_ro", d, 32'h0);
    rd(2'd1, d); chk("ctrl_after_ro", d, 32'h0);
    rd(2'd3, d); chk("ack_reads0", d, 32'h0);

    // T1: down auto-reload, period RELOAD+2
    wr(2'd0, 32'd3);
    wr(2'd1, 32'h3);
    run_load(0, 15, period(32'd3, 1'b0));
    rd(2'd2, d); chk("t1_status", d, status_exp(3, 1, 1'b1));
    chkb("t1_irq_masked", o_irq, 1'b0);
    wr(2'd1, 32'h10);
    rd(2'd2, d); chk("t1_clr_status", d, status_exp(0, 0, 1'b1));
    rd(2'd1, d); chk("t1_clr_ctrl", d, 32'h2);
    wr(2'd3, 32'h1);
    rd(2'd2, d); chk("t1_ack", d, 32'h0);

    // T2: one-shot
    wr(2'd0, 32'd2);
    wr(2'd1, 32'h1);
    for (int k = 0; k < 6; k++) begin
      chkb("t2_load", o_load, k >= 4);
      tick();
    end
    rd(2'd2, d); chk("t2_status", d, status_exp(1, 0, 1'b1));
    rd(2'd1, d); chk("t2_ctrl", d, 32'h0);
    chk("t2_cnt_held", m_cnt, 32'd2);
    chk("t2_pdata", o_pdata, 32'd2);
    wr(2'd3, 32'h1);
    wr(2'd1, 32'h10);

    // T3: pause / resume
    wr(2'd0, 32'd10);
    wr(2'd1, 32'h3);
    run_load(0, 4, period(32'd10, 1'b0));
    chk("t3_cnt6", m_cnt, 32'd6);
    wr(2'd1, 32'h2);
    for (int k = 0; k < 20; k++) begin
      chk("t3_frozen", m_cnt, 32'd5);
      tick();
    end
    rd(2'd2, d); chk("t3_pause_status", d, status_exp(0, 2, 1'b0));
    wr(2'd1, 32'h3);
    for (int k = 0; k < 4; k++) begin
      chk("t3_resume", m_cnt, 32'd5 - 32'(k));
      tick();
    end
    rd(2'd2, d); chk("t3_no_irq", d, status_exp(0, 1, 1'b0));
    wr(2'd1, 32'h10);

    // T4: up mode, dir write while running is ignored
    wr(2'd0, 32'hFFFF_FFFD);
    wr(2'd1, 32'h7);
    chkb("t4_s", o_s, 1'b1);
    run_load(0, 8, period(32'hFFFF_FFFD, 1'b1));
    wr(2'd1, 32'h3);
    chkb("t4_s_kept", o_s, 1'b1);
    rd(2'd1, d); chk("t4_ctrl", d, 32'h7);
    run_load(9, 16, period(32'hFFFF_FFFD, 1'b1));
    rd(2'd2, d); chk("t4_status", d, status_exp(4, 1, 1'b1));
    wr(2'd1, 32'h10);
    wr(2'd3, 32'h1);

    // T5: stale Rc across IDLE->RUN
    force_rc = 1'b1;
    wr(2'd0, 32'd20);
    wr(2'd1, 32'h3);
    chkb("t5_load", o_load, 1'b0);
    force_rc = 1'b0;
    tick();
    tick();
    rd(2'd2, d); chk("t5_status", d, status_exp(0, 1, 1'b0));
    chkb("t5_irq", o_irq, 1'b0);
    wr(2'd1, 32'h10);

    // Randomized reloads, both directions
    for (int it = 0; it < 6; it++) begin
      up = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      r  = up ? (32'hFFFF_FFFF - $urandom_range(0, 9)) : $urandom_range(0, 9);
      n  = int'($urandom_range(8, 40));
      p  = period(r, up);
      wr(2'd0, r);
      wr(2'd1, {28'h0, ie, up, 1'b1, 1'b1});
      chkb("rnd_s", o_s, up);
      run_load(0, n, p);
      rd(2'd2, d); chk("rnd_status", d, status_exp(int'(longint'(n) / p), 1, longint'(n) >= p));
      chkb("rnd_irq", o_irq, ie & (longint'(n) >= p));
      wr(2'd1, 32'h10);
      wr(2'd3, 32'h1);
      rd(2'd2, d); chk("rnd_cleared", d, 32'h0);
    end

    // T6: ACK vs expiry, pause vs expiry, reset mid-run
    wr(2'd0, 32'd3);
    wr(2'd1, 32'hB);
    run_load(0, 4, period(32'd3, 1'b0));
    wr(2'd3, 32'h1);
    rd(2'd2, d); chk("t6_ack_lost", d, status_exp(1, 1, 1'b1));
    chkb("t6_irq", o_irq, 1'b1);
    wr(2'd3, 32'h1);
    rd(2'd2, d); chk("t6_ack", d, status_exp(1, 1, 1'b0));
    chkb("t6_irq_clr", o_irq, 1'b0);
    run_load(6, 9, period(32'd3, 1'b0));
    chkb("t6_evt_load", o_load, 1'b1);
    wr(2'd1, 32'hA);
    rd(2'd2, d); chk("t6_pause_evt", d, status_exp(2, 2, 1'b1));
    chk("t6_reloaded", m_cnt, 32'd3);
    tick();
    chk("t6_frozen", m_cnt, 32'd3);
    wr(2'd1, 32'hB);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chkb("t6_rst_load", o_load, 1'b1);
    chk("t6_rst_pdata", o_pdata, 32'h0);
    chkb("t6_rst_s", o_s, 1'b0);
    chkb("t6_rst_irq", o_irq, 1'b0);
    rd(2'd2, d); chk("t6_rst_status", d, 32'h0);
    rd(2'd1, d); chk("t6_rst_ctrl", d, 32'h0);
    rd(2'd0, d); chk("t6_rst_reload", d, 32'h0);
    tick();
    chk("t6_rst_cnt", m_cnt, 32'h0);
    rst_n = 1'b1;
    tick();
    chkb("t6_post_load", o_load, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
